// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the IF/MEM unified-bus arbiter.
package mem_arbiter_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEL_W = 4;

    localparam logic [CNT_W-1:0] ARB_TIMEOUT_DEFAULT = 8'd255;
    localparam logic [SEL_W-1:0] ARB_SEL_ALL         = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_IF_WAIT  = 2'd1,
        ARB_MEM_WAIT = 2'd2,
        ARB_DONE     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority (MEM over IF) arbiter for one unified memory bus, with a
// bus_req/bus_ack wait-state handshake, abort timeout and registered results.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 32'(ARB_TIMEOUT_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              bus_req,
    output logic              bus_we,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              stallreq,
    output logic              bus_err
);

    arb_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [SEL_W-1:0]  r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;
    logic              r_bus_err;

    logic              w_timeout;
    logic              w_finish;
    logic [DATA_W-1:0] w_cap_data;

    // An ack in the timeout cycle still counts as a successful access.
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_finish   = bus_ack | w_timeout;
    assign w_cap_data = bus_ack ? bus_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (mem_ce) begin
                        r_state     <= ARB_MEM_WAIT;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_sel   <= mem_sel;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                    end else if (if_req) begin
                        r_state     <= ARB_IF_WAIT;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_sel   <= ARB_SEL_ALL;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= '0;
                    end
                end
                ARB_IF_WAIT, ARB_MEM_WAIT: begin
                    if (w_finish) begin
                        r_state   <= ARB_DONE;
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                        if (!bus_ack) begin
                            r_bus_err <= 1'b1;
                        end
                        if (r_state == ARB_IF_WAIT) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= w_cap_data;
                        end else begin
                            r_mem_ready <= 1'b1;
                            if (!r_bus_we) begin
                                r_mem_rdata <= w_cap_data;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // One dead cycle so the still-held request is not relaunched.
                ARB_DONE: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_sel   = r_bus_sel;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign mem_rdata = r_mem_rdata;
    assign mem_ready = r_mem_ready;
    assign bus_err   = r_bus_err;

    assign stallreq = (if_req & ~r_if_ready) | (mem_ce & ~r_mem_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-schedule model plus directed pins and random traffic.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stallreq;
    logic        bus_err;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq(stallreq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Transaction model: one access owns the bus from launch cycle t0; it ends
    // after e = min(d, T-1) wait cycles, ready at t0+2+e, bus free at t0+3+e.
    int          cyc = 0;
    int          owner = 0;            // 0 none, 1 IF, 2 MEM
    int          t0 = 0, d = 0, e = 0;
    bit          acked = 0;
    logic [31:0] l_addr = 0, l_wdata = 0, cap = 0;
    logic        l_we = 0;
    logic [3:0]  l_sel = 0;

    logic        exp_req = 0, exp_we = 0, exp_ifr = 0, exp_memr = 0, exp_err = 0, exp_stall = 0;
    logic [3:0]  exp_sel = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_if_rdata = 0, exp_mem_rdata = 0;

    // Requester / bus stimulus state
    bit          rnd_mode = 0;
    int          force_d = -1;
    bit          frd_en = 0;
    logic [31:0] frd_val = 0;
    bit          if_pend = 0, mem_pend = 0;
    logic [31:0] if_a = 0, m_a = 0, m_wd = 0;
    logic        m_we = 0;
    logic [3:0]  m_sel = 0;

    // Per-test observation bit-vectors (bit i = cycle i of the test)
    int          rec_idx = 0;
    logic [31:0] obs_req = 0, obs_ifr = 0, obs_memr = 0, obs_stall = 0;
    logic        w_we = 0;
    logic [3:0]  w_sel = 0;
    logic [31:0] w_wdata = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic launch(input int who, input logic [31:0] a, input logic we,
                          input logic [3:0] sel, input logic [31:0] wd);
        owner = who; t0 = cyc; cap = 32'h0;
        l_addr = a; l_we = we; l_sel = sel; l_wdata = wd;
        if (force_d >= 0) d = force_d;
        else if ($urandom_range(0, 7) == 0) d = int'($urandom_range(T - 1, T + 3));
        else d = int'($urandom_range(0, T - 1));
        e = (d < T - 1) ? d : T - 1;
        acked = (d <= T - 1);
    endtask

    task automatic step();
        @(negedge clk);
        if (owner != 0 && cyc >= t0 + 3 + e) owner = 0;
        if (owner != 0 && cyc == t0 + 1) begin
            exp_addr = l_addr; exp_we = l_we; exp_sel = l_sel; exp_wdata = l_wdata;
        end
        exp_ifr = 1'b0;
        exp_memr = 1'b0;
        if (owner != 0 && cyc == t0 + 2 + e) begin
            if (owner == 1) begin
                exp_ifr = 1'b1; exp_if_rdata = cap;
            end else begin
                exp_memr = 1'b1;
                if (!l_we) exp_mem_rdata = cap;
            end
            if (!acked) exp_err = 1'b1;
        end
        exp_req = (owner != 0) && (cyc >= t0 + 1) && (cyc <= t0 + 1 + e);

        if (rnd_mode) begin
            if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1; if_a = $urandom;
            end
            if (!mem_pend && $urandom_range(0, 3) == 0) begin
                mem_pend = 1; m_a = $urandom; m_wd = $urandom;
                m_we = 1'($urandom_range(0, 1)); m_sel = 4'($urandom);
            end
        end
        if_req    = if_pend;
        if_addr   = if_pend ? if_a : $urandom;
        mem_ce    = mem_pend;
        mem_addr  = mem_pend ? m_a : $urandom;
        mem_we    = mem_pend ? m_we : 1'($urandom_range(0, 1));
        mem_sel   = mem_pend ? m_sel : 4'($urandom);
        mem_wdata = mem_pend ? m_wd : $urandom;

        if (owner == 0) begin
            if (mem_pend) launch(2, m_a, m_we, m_sel, m_wd);
            else if (if_pend) launch(1, if_a, 1'b0, 4'hF, 32'h0);
        end
        bus_rdata = frd_en ? frd_val : $urandom;
        bus_ack   = (owner != 0) && acked && (cyc == t0 + 1 + d);
        if (bus_ack) cap = bus_rdata;
        exp_stall = (if_req & ~exp_ifr) | (mem_ce & ~exp_memr);

        #1;
        chk("bus_req",   32'(bus_req),   32'(exp_req));
        chk("bus_addr",  bus_addr,       exp_addr);
        chk("bus_we",    32'(bus_we),    32'(exp_we));
        chk("bus_sel",   32'(bus_sel),   32'(exp_sel));
        chk("bus_wdata", bus_wdata,      exp_wdata);
        chk("if_ready",  32'(if_ready),  32'(exp_ifr));
        chk("mem_ready", 32'(mem_ready), 32'(exp_memr));
        chk("if_rdata",  if_rdata,       exp_if_rdata);
        chk("mem_rdata", mem_rdata,      exp_mem_rdata);
        chk("bus_err",   32'(bus_err),   32'(exp_err));
        chk("stallreq",  32'(stallreq),  32'(exp_stall));

        if (rec_idx < 32) begin
            obs_req[5'(rec_idx)]   = bus_req;
            obs_ifr[5'(rec_idx)]   = if_ready;
            obs_memr[5'(rec_idx)]  = mem_ready;
            obs_stall[5'(rec_idx)] = stallreq;
        end
        if (rec_idx == 1) begin
            w_we = bus_we; w_sel = bus_sel; w_wdata = bus_wdata;
        end
        rec_idx++;
        if (exp_ifr) if_pend = 0;
        if (exp_memr) mem_pend = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic start_rec();
        rec_idx = 0; obs_req = 0; obs_ifr = 0; obs_memr = 0; obs_stall = 0;
    endtask

    task automatic model_reset();
        owner = 0; cap = 0; if_pend = 0; mem_pend = 0;
        exp_req = 0; exp_we = 0; exp_sel = 0; exp_addr = 0; exp_wdata = 0;
        exp_if_rdata = 0; exp_mem_rdata = 0; exp_err = 0;
    endtask

    initial begin
        rst = 1'b0; if_req = 0; if_addr = 0; mem_ce = 0; mem_we = 0; mem_sel = 0;
        mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_bus_req",   32'(bus_req),   32'h0);
        chk("rst_if_ready",  32'(if_ready),  32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_bus_err",   32'(bus_err),   32'h0);
        chk("rst_bus_addr",  bus_addr,       32'h0);
        chk("rst_stallreq",  32'(stallreq),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        // IF-only read, zero-wait ack
        idle(2); start_rec();
        force_d = 0; frd_en = 1; frd_val = 32'h3C010001;
        if_pend = 1; if_a = 32'h0000_0010;
        repeat (4) step();
        chk("t1_bus_req_seq",  obs_req & 32'hF,   32'h2);
        chk("t1_if_ready_seq", obs_ifr & 32'hF,   32'h4);
        chk("t1_stall_seq",    obs_stall & 32'hF, 32'h3);
        chk("t1_if_rdata",     if_rdata,          32'h3C010001);

        // Simultaneous IF + MEM read, 3 wait cycles each
        idle(2); start_rec();
        force_d = 3; frd_val = 32'hDEADBEEF;
        if_pend = 1; if_a = 32'h0000_0200;
        mem_pend = 1; m_a = 32'h0000_0100; m_we = 0; m_sel = 4'hF; m_wd = 32'h0;
        repeat (14) step();
        chk("t2_bus_req_seq",   obs_req & 32'h3FFF,   32'h79E);
        chk("t2_mem_ready_seq", obs_memr & 32'h3FFF,  32'h20);
        chk("t2_if_ready_seq",  obs_ifr & 32'h3FFF,   32'h800);
        chk("t2_stall_seq",     obs_stall & 32'h3FFF, 32'h7FF);
        chk("t2_mem_rdata",     mem_rdata,            32'hDEADBEEF);

        // MEM write: bus mirrors the store, mem_rdata untouched
        idle(2); start_rec();
        force_d = 0; frd_val = 32'h55AA55AA;
        mem_pend = 1; m_we = 1; m_sel = 4'b0011; m_a = 32'h0000_0040; m_wd = 32'h0000ABCD;
        repeat (4) step();
        chk("t3_mem_ready_seq", obs_memr & 32'hF, 32'h4);
        chk("t3_bus_we",        32'(w_we),        32'h1);
        chk("t3_bus_sel",       32'(w_sel),       32'h3);
        chk("t3_bus_wdata",     w_wdata,          32'h0000ABCD);
        chk("t3_mem_rdata",     mem_rdata,        32'hDEADBEEF);

        // Ack in the same cycle the timeout is reached
        idle(2); start_rec();
        force_d = 3; frd_val = 32'h12345678;
        if_pend = 1; if_a = 32'h0000_0080;
        repeat (7) step();
        chk("t5_bus_req_seq", obs_req & 32'h7F, 32'h1E);
        chk("t5_if_ready",    obs_ifr & 32'h7F, 32'h20);
        chk("t5_if_rdata",    if_rdata,         32'h12345678);
        chk("t5_bus_err",     32'(bus_err),     32'h0);

        // No ack at all: abort after TIMEOUT wait cycles
        idle(2); start_rec();
        force_d = 99;
        if_pend = 1; if_a = 32'h0000_00C0;
        repeat (7) step();
        chk("t4_bus_req_seq", obs_req & 32'h7F, 32'h1E);
        chk("t4_if_ready",    obs_ifr & 32'h7F, 32'h20);
        chk("t4_if_rdata",    if_rdata,         32'h0);
        chk("t4_bus_err",     32'(bus_err),     32'h1);
        idle(5);
        chk("t4_bus_err_sticky", 32'(bus_err), 32'h1);

        // Asynchronous reset in the middle of a MEM wait
        idle(2);
        force_d = 99;
        mem_pend = 1; m_we = 0; m_a = 32'h0000_0300; m_sel = 4'hF; m_wd = 32'h0;
        repeat (3) step();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_bus_req",   32'(bus_req),   32'h0);
        chk("t6_mem_ready", 32'(mem_ready), 32'h0);
        chk("t6_bus_err",   32'(bus_err),   32'h0);
        chk("t6_mem_rdata", mem_rdata,      32'h0);
        chk("t6_bus_addr",  bus_addr,       32'h0);
        mem_ce = 0;
        #1;
        chk("t6_stallreq", 32'(stallreq), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        start_rec();
        idle(6);
        chk("t6_no_spurious_ready", (obs_ifr | obs_memr) & 32'h3F, 32'h0);
        chk("t6_no_bus_req",        obs_req & 32'h3F,              32'h0);

        // Random traffic against the model
        rnd_mode = 1; force_d = -1; frd_en = 0;
        repeat (3000) step();
        rnd_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
